// File: rtl/pe_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : pe_feeder
//  Purpose  : Operand streamer for a single processing element. The host
//             loads an X vector and a W vector into local buffers, then
//             requests a stream of len (x,w) pairs. Pairs go out back-to-back,
//             one per cycle. Returned PE result beats are counted, and done
//             pulses once every issued operand has come back. err flags a
//             bad length, a stray result beat, or a result timeout.
//  Ports    : iclk, irstn           clock, asynchronous active-low reset
//             ld_en/ld_sel/ld_addr/ld_data  buffer write port (X=0, W=1)
//             start, len            stream request and pair count (0..DEPTH)
//             pe_xdata/pe_wdata/pe_ivalid   registered operand stream to PE
//             pe_ovalid             result beat returned by the PE
//             busy, done, err       registered status outputs
//  Revision : 1.0  initial release
// ============================================================================
module pe_feeder #(
    parameter int WORDSIZE = 16,
    parameter int ADDRW    = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                iclk,
    input  logic                irstn,
    input  logic                ld_en,
    input  logic                ld_sel,
    input  logic [ADDRW-1:0]    ld_addr,
    input  logic [WORDSIZE-1:0] ld_data,
    input  logic                start,
    input  logic [ADDRW:0]      len,
    output logic [WORDSIZE-1:0] pe_xdata,
    output logic [WORDSIZE-1:0] pe_wdata,
    output logic                pe_ivalid,
    input  logic                pe_ovalid,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int DEPTH = 2 ** ADDRW;
    localparam int CW    = ADDRW + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       len_q, len_d;
    logic [CW-1:0]       issue_q, issue_d;
    logic [CW-1:0]       ret_q, ret_d;
    logic [TW-1:0]       wait_q, wait_d;
    logic [WORDSIZE-1:0] xdata_q, xdata_d;
    logic [WORDSIZE-1:0] wdata_q, wdata_d;
    logic                ivalid_q, ivalid_d;
    logic                busy_q;
    logic                done_q;
    logic                err_q, err_d;

    // Operand buffers: plain storage, intentionally not reset.
    logic [WORDSIZE-1:0] x_mem_q [DEPTH];
    logic [WORDSIZE-1:0] w_mem_q [DEPTH];

    logic                w_ld_ok;
    logic                w_wr_x;
    logic                w_wr_w;
    logic                w_active;
    logic                w_stray;
    logic [ADDRW-1:0]    w_rd_idx;
    logic [WORDSIZE-1:0] w_x_rd;
    logic [WORDSIZE-1:0] w_w_rd;

    // Loads are accepted whenever the block is not busy (IDLE or DONE).
    assign w_ld_ok  = (state_q == IDLE) || (state_q == DONE);
    assign w_wr_x   = ld_en && w_ld_ok && !ld_sel;
    assign w_wr_w   = ld_en && w_ld_ok &&  ld_sel;
    assign w_active = (state_q == STREAM) || (state_q == DRAIN);

    // A result beat is stray if nothing is outstanding.
    assign w_stray  = pe_ovalid && (!w_active || (ret_q == len_q));

    // The first beat is fetched on the start edge (index 0); later beats use
    // the issue counter.
    assign w_rd_idx = (state_q == IDLE) ? '0 : issue_q[ADDRW-1:0];

    // Write-through bypass so a load on the start edge reaches the stream.
    assign w_x_rd = (w_wr_x && (ld_addr == w_rd_idx)) ? ld_data : x_mem_q[w_rd_idx];
    assign w_w_rd = (w_wr_w && (ld_addr == w_rd_idx)) ? ld_data : w_mem_q[w_rd_idx];

    always_ff @(posedge iclk) begin
        if (w_wr_x) begin
            x_mem_q[ld_addr] <= ld_data;
        end
        if (w_wr_w) begin
            w_mem_q[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issue_d  = issue_q;
        ret_d    = ret_q;
        wait_d   = wait_q;
        xdata_d  = xdata_q;
        wdata_d  = wdata_q;
        ivalid_d = 1'b0;
        err_d    = w_stray;

        if (pe_ovalid && !w_stray) begin
            ret_d = ret_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else if (len > CW'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        len_d    = len;
                        ret_d    = '0;
                        issue_d  = CW'(1);
                        xdata_d  = w_x_rd;
                        wdata_d  = w_w_rd;
                        ivalid_d = 1'b1;
                        state_d  = STREAM;
                    end
                end
            end
            STREAM: begin
                if (issue_q < len_q) begin
                    xdata_d  = w_x_rd;
                    wdata_d  = w_w_rd;
                    ivalid_d = 1'b1;
                    issue_d  = issue_q + 1'b1;
                end else begin
                    wait_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Completion takes priority over a coincident timeout.
                if (ret_d == len_q) begin
                    state_d = DONE;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issue_q  <= '0;
            ret_q    <= '0;
            wait_q   <= '0;
            xdata_q  <= '0;
            wdata_q  <= '0;
            ivalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issue_q  <= issue_d;
            ret_q    <= ret_d;
            wait_q   <= wait_d;
            xdata_q  <= xdata_d;
            wdata_q  <= wdata_d;
            ivalid_q <= ivalid_d;
            busy_q   <= (state_d == STREAM) || (state_d == DRAIN);
            done_q   <= (state_d == DONE);
            err_q    <= err_d;
        end
    end

    assign pe_xdata  = xdata_q;
    assign pe_wdata  = wdata_q;
    assign pe_ivalid = ivalid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_feeder
//  Purpose  : Scoreboard bench for pe_feeder with a latency-3 model PE.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pe_feeder;

    localparam int WORDSIZE = 16;
    localparam int ADDRW    = 4;
    localparam int TIMEOUT  = 15;
    localparam int DEPTH    = 2 ** ADDRW;

    localparam int K_IVALID = 0;
    localparam int K_BUSY   = 1;
    localparam int K_XDATA  = 2;
    localparam int K_WDATA  = 3;

    typedef struct {
        logic [WORDSIZE-1:0] x;
        logic [WORDSIZE-1:0] w;
    } beat_t;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } probe_t;

    logic                iclk = 1'b0;
    logic                irstn;
    logic                ld_en;
    logic                ld_sel;
    logic [ADDRW-1:0]    ld_addr;
    logic [WORDSIZE-1:0] ld_data;
    logic                start;
    logic [ADDRW:0]      len;
    logic [WORDSIZE-1:0] pe_xdata;
    logic [WORDSIZE-1:0] pe_wdata;
    logic                pe_ivalid;
    logic                pe_ovalid;
    logic                busy;
    logic                done;
    logic                err;

    pe_feeder #(
        .WORDSIZE (WORDSIZE),
        .ADDRW    (ADDRW),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .iclk      (iclk),
        .irstn     (irstn),
        .ld_en     (ld_en),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .start     (start),
        .len       (len),
        .pe_xdata  (pe_xdata),
        .pe_wdata  (pe_wdata),
        .pe_ivalid (pe_ivalid),
        .pe_ovalid (pe_ovalid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    // Model PE: returns one beat three cycles after each valid input,
    // optionally swallowing the first drop_req returns.
    logic p1 = 1'b0, p2 = 1'b0, ov = 1'b0;
    logic inject = 1'b0;
    int   drop_req = 0;
    int   dropped  = 0;
    always @(posedge iclk) begin
        p1 <= pe_ivalid;
        p2 <= p1;
        if (p2 && (dropped < drop_req)) begin
            ov      <= 1'b0;
            dropped <= dropped + 1;
        end else begin
            ov <= p2;
        end
    end
    assign pe_ovalid = ov | inject;

    // Scoreboard queues filled by stimulus, drained by the monitor.
    beat_t  beat_q[$];
    probe_t probe_q[$];
    int     done_q[$];
    int     err_q[$];
    logic   tb_end = 1'b0;

    logic [WORDSIZE-1:0] xm [DEPTH];
    logic [WORDSIZE-1:0] wm [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic bad(input string name);
        n_checks++;
        $display("FAIL %s at cycle %0d: got event expected none", name, cyc);
    endtask

    always @(negedge iclk) begin
        beat_t  b;
        probe_t p;
        logic [31:0] a;
        if (pe_ivalid) begin
            if (beat_q.size() == 0) begin
                bad("beat_unexpected");
            end else begin
                b = beat_q.pop_front();
                chk("beat_x", 32'(pe_xdata), 32'(b.x));
                chk("beat_w", 32'(pe_wdata), 32'(b.w));
            end
        end
        if (done) begin
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                void'(done_q.pop_front());
                chk("done_pulse", 32'(done), 32'd1);
            end else begin
                bad("done_unexpected");
            end
        end
        while (done_q.size() > 0 && done_q[0] <= cyc) begin
            void'(done_q.pop_front());
            chk("done_missing", 32'(done), 32'd1);
        end
        if (err) begin
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                void'(err_q.pop_front());
                chk("err_pulse", 32'(err), 32'd1);
            end else begin
                bad("err_unexpected");
            end
        end
        while (err_q.size() > 0 && err_q[0] <= cyc) begin
            void'(err_q.pop_front());
            chk("err_missing", 32'(err), 32'd1);
        end
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            case (p.kind)
                K_IVALID: a = 32'(pe_ivalid);
                K_BUSY:   a = 32'(busy);
                K_XDATA:  a = 32'(pe_xdata);
                default:  a = 32'(pe_wdata);
            endcase
            if (p.cyc < cyc) chk("probe_late", 32'(p.cyc), 32'(cyc));
            else             chk($sformatf("probe_k%0d", p.kind), a, p.val);
        end
        if (tb_end) begin
            chk("beats_left", 32'(beat_q.size()), 32'd0);
            chk("events_left", 32'(done_q.size() + err_q.size()), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic probe(input int c, input int kind, input logic [31:0] val);
        probe_t p;
        p.cyc  = c;
        p.kind = kind;
        p.val  = val;
        probe_q.push_back(p);
    endtask

    task automatic load(input logic sel, input int addr, input logic [WORDSIZE-1:0] data);
        if (sel) wm[addr] = data;
        else     xm[addr] = data;
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = ADDRW'(addr);
        ld_data = data;
        tick(1);
        ld_en   = 1'b0;
    endtask

    // Issues a start and pushes everything the DUT should produce for it.
    // drop != 0 means the model PE loses one return, so a timeout is expected.
    task automatic run_stream(input int l, input int drop, output int s);
        beat_t b;
        s = cyc;
        if (l == 0) begin
            done_q.push_back(s + 1);
            probe(s + 1, K_IVALID, 0);
            probe(s + 1, K_BUSY, 0);
        end else if (l > DEPTH) begin
            err_q.push_back(s + 1);
            probe(s + 1, K_IVALID, 0);
            probe(s + 1, K_BUSY, 0);
        end else begin
            for (int i = 0; i < l; i++) begin
                b.x = xm[i];
                b.w = wm[i];
                beat_q.push_back(b);
            end
            probe(s + 1, K_IVALID, 1);
            probe(s + 1, K_BUSY, 1);
            probe(s + l + 1, K_IVALID, 0);
            probe(s + l + 1, K_XDATA, 32'(xm[l-1]));
            if (drop == 0) begin
                probe(s + l + 3, K_BUSY, 1);
                probe(s + l + 4, K_BUSY, 0);
                done_q.push_back(s + l + 4);
            end else begin
                probe(s + l + TIMEOUT, K_BUSY, 1);
                probe(s + l + 1 + TIMEOUT, K_BUSY, 0);
                err_q.push_back(s + l + 1 + TIMEOUT);
            end
        end
        start = 1'b1;
        len   = (ADDRW+1)'(l);
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        int c;
        irstn   = 1'b0;
        ld_en   = 1'b0;
        ld_sel  = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        start   = 1'b0;
        len     = '0;
        tick(2);
        // Reset state
        probe(cyc, K_IVALID, 0);
        probe(cyc, K_BUSY, 0);
        probe(cyc, K_XDATA, 0);
        probe(cyc, K_WDATA, 0);
        tick(1);
        irstn = 1'b1;
        tick(1);

        // Basic stream of four pairs
        for (int i = 0; i < 8; i++) begin
            load(1'b0, i, WORDSIZE'(i + 1));
            load(1'b1, i, WORDSIZE'(i + 10));
        end
        run_stream(4, 0, s);
        tick(10);

        // Zero length completes immediately
        run_stream(0, 0, s);
        tick(3);

        // Length beyond depth is rejected, and a coincident stray beat
        // must not produce a second err pulse
        inject = 1'b1;
        run_stream(DEPTH + 1, 0, s);
        inject = 1'b0;
        tick(3);

        // Full-depth stream
        for (int i = 8; i < DEPTH; i++) begin
            load(1'b0, i, WORDSIZE'(16'h100 + i));
            load(1'b1, i, WORDSIZE'(16'h200 + i));
        end
        run_stream(DEPTH, 0, s);
        tick(DEPTH + 8);

        // Missing return -> timeout
        drop_req = 1;
        run_stream(4, 1, s);
        tick(22);

        // Stray beat while idle
        c = cyc;
        err_q.push_back(c + 1);
        inject = 1'b1;
        tick(1);
        inject = 1'b0;
        tick(3);

        // Load during a stream is ignored
        run_stream(4, 0, s);
        ld_en   = 1'b1;
        ld_sel  = 1'b0;
        ld_addr = '0;
        ld_data = 16'hFFFF;
        tick(1);
        ld_en   = 1'b0;
        tick(8);
        run_stream(1, 0, s);
        tick(7);

        // Load and start on the same edge: the new word is streamed
        xm[0]   = 16'h0055;
        ld_en   = 1'b1;
        ld_sel  = 1'b0;
        ld_addr = '0;
        ld_data = 16'h0055;
        run_stream(1, 0, s);
        ld_en   = 1'b0;
        tick(7);

        // Asynchronous reset at the second beat of an eight-pair stream
        s = cyc;
        begin
            beat_t b;
            b.x = xm[0];
            b.w = wm[0];
            beat_q.push_back(b);
        end
        probe(s + 2, K_IVALID, 0);
        probe(s + 2, K_BUSY, 0);
        probe(s + 2, K_XDATA, 0);
        probe(s + 2, K_WDATA, 0);
        start = 1'b1;
        len   = (ADDRW+1)'(8);
        tick(1);
        start = 1'b0;
        tick(1);
        irstn = 1'b0;
        tick(4);
        irstn = 1'b1;
        tick(1);
        run_stream(2, 0, s);
        tick(8);

        tb_end = 1'b1;
        tick(3);
    end

endmodule
`default_nettype wire
